// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchroniser, mid-bit sampling and
// a valid/ready output register that reports framing errors and overruns as pulses.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 10_000
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CPB);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] MID = CW'(CPB / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t state;
    logic [1:0] sync;
    logic [CW-1:0] bit_cnt;
    logic [2:0] index;
    logic [7:0] shreg;
    logic rxs;
    logic deliver;

    assign rxs = sync[1];
    assign deliver = state == STOP && bit_cnt == LAST && rxs;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sync <= 2'b11;
            state <= IDLE;
            bit_cnt <= '0;
            index <= '0;
            shreg <= '0;
            rx_data_o <= '0;
            valid_o <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            sync <= {sync[0], rx_i};
            frame_err_o <= 1'b0;
            overrun_o <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    state <= rxs ? IDLE : START;
                end
                START: begin
                    bit_cnt <= bit_cnt == MID ? '0 : bit_cnt + 1'b1;
                    index <= '0;
                    if (bit_cnt == MID)
                        state <= rxs ? IDLE : DATA;
                end
                DATA: begin
                    bit_cnt <= bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
                    if (bit_cnt == LAST) begin
                        shreg[index] <= rxs;
                        index <= index + 1'b1;
                        state <= index == 3'd7 ? STOP : DATA;
                    end
                end
                STOP: begin
                    bit_cnt <= bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
                    if (bit_cnt == LAST) begin
                        frame_err_o <= !rxs;
                        state <= rxs ? IDLE : BREAK;
                    end
                end
                BREAK: state <= rxs ? IDLE : BREAK;
                default: state <= IDLE;
            endcase
            // A pending byte that is being consumed this cycle frees the slot for the new one.
            if (deliver) begin
                if (valid_o && !ready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    rx_data_o <= shreg;
                    valid_o <= 1'b1;
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic rx = 1'b1;
    logic ready = 1'b1;
    logic [7:0] rx_data;
    logic valid, frame_err, overrun;

    int checks = 0;
    int errs = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
        .clk_i(clk),
        .nreset_i(nreset),
        .rx_i(rx),
        .rx_data_o(rx_data),
        .valid_o(valid),
        .ready_i(ready),
        .frame_err_o(frame_err),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; the monitor looks on the falling edge,
    // where it sees exactly what the DUT will act on at the next rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int bits);
        rx = v;
        tick(bits * CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_bits, input bit push);
        if (push) exp_q.push_back(b);
        drive_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
        drive_bit(stop, stop_bits);
        rx = 1'b1;
    endtask

    task automatic finish_test(input string tag, input int exp_fe, input int exp_ov);
        tick(2 * CPB);
        check({tag, " pending"}, exp_q.size(), 0);
        check({tag, " frame_err"}, fe_cnt, exp_fe);
        check({tag, " overrun"}, ov_cnt, exp_ov);
        fe_cnt = 0;
        ov_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (nreset) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (valid && ready) begin
                check("byte expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        tick(3);
        check("rst data", rx_data, 0);
        check("rst valid", valid, 0);
        check("rst frame_err", frame_err, 0);
        check("rst overrun", overrun, 0);
        nreset = 1'b1;
        tick(CPB);

        send_byte(8'h6C, 1'b1, 1, 1);
        finish_test("t1", 0, 0);

        send_byte(8'h88, 1'b1, 1, 1);
        send_byte(8'h55, 1'b1, 1, 1);
        finish_test("t2", 0, 0);

        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(CPB);
        check("t3 idle", dut.state, 0);
        finish_test("t3", 0, 0);

        send_byte(8'hA5, 1'b0, 2, 0);
        tick(CPB);
        send_byte(8'h3C, 1'b1, 1, 1);
        finish_test("t4", 1, 0);

        ready = 1'b0;
        send_byte(8'h11, 1'b1, 1, 1);
        send_byte(8'h22, 1'b1, 1, 0);
        tick(CPB);
        check("t5 valid held", valid, 1);
        check("t5 data held", rx_data, 8'h11);
        ready = 1'b1;
        tick(3);
        check("t5 valid cleared", valid, 0);
        finish_test("t5", 0, 1);

        drive_bit(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_bit(i[0], 1);
        rx = 1'b1;
        tick(CPB / 2);
        nreset = 1'b0;
        #2;
        check("t6 rst valid", valid, 0);
        check("t6 rst data", rx_data, 0);
        tick(3);
        nreset = 1'b1;
        tick(CPB);
        send_byte(8'h7E, 1'b1, 1, 1);
        finish_test("t6", 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
